sram_row_access_ctrl: RTL and testbench
=======================================

// Module: sram_row_access_ctrl
// PURPOSE
// - Sequences one SRAM row access through the 2-to-4 predecoder stage and shares it between two requesters.
// - Round-robin arbitration between port 0 and port 1.
// - Per access, runs precharge -> predecode -> wordline pulse -> recover, then pulses done.
// - Sits between the bank interface and the row predecoders; drives predecoder inputs, predecode enable, precharge and wordline enable.
// PARAMETERS
// - ADDR_W      4  row address width; fixed at 4 (two 2-bit predecoder groups); any other value is a config error
// - PRE_CYCLES  1  cycles in PRECHARGE, range 1..15
// - WL_CYCLES   2  cycles wordline held high in ACTIVE, range 1..15
// PORTS
// - clk          in   1       single clock, all state updates on rising edge
// - rst_n        in   1       reset, synchronous, active-low
// - req0_valid   in   1       port 0 request
// - req0_addr    in   ADDR_W  port 0 row address
// - req0_we      in   1       port 0 write (1) / read (0)
// - req0_ready   out  1       port 0 accepted this cycle
// - req1_valid   in   1       port 1 request
// - req1_addr    in   ADDR_W  port 1 row address
// - req1_we      in   1       port 1 write (1) / read (0)
// - req1_ready   out  1       port 1 accepted this cycle
// - predec_hi    out  2       row address [3:2] to upper predecoder
// - predec_lo    out  2       row address [1:0] to lower predecoder
// - predec_en    out  1       predecode gate; high DECODE..RECOVER
// - precharge_n  out  1       bitline precharge, active-low
// - wl_en        out  1       wordline enable
// - we_out       out  1       latched write flag for the current access
// - done         out  1       one-cycle pulse when the access completes
// - done_id      out  1       port that owns the completing access; valid with done
// BEHAVIOUR
// - Reset when rst_n=0 at a clock edge:
//   - state=IDLE; rr pointer=port 0.
//   - predec_hi=predec_lo=0; predec_en=wl_en=we_out=done=done_id=0; precharge_n=1.
//   - Applies mid-access too; the wordline drops on that edge, and no done is issued for the aborted access.
// - Handshake:
//   - reqN_ready is combinational and asserted only in IDLE, for the arbitration winner.
//   - Accept = reqN_valid & reqN_ready.
//   - Requester holds valid/addr/we stable until accepted.
//   - At most one ready is high per cycle.
// - Arbitration:
//   - Only one valid: that port wins.
//   - Both valid: the rr pointer port wins.
//   - Pointer moves to the other port after every accept.
// - On accept, latch addr, we and id. Next state is PRECHARGE.
// - PRECHARGE: precharge_n=0 for PRE_CYCLES cycles; wl_en=0; predec_en=0.
// - DECODE (1 cycle):
//   - precharge_n=1; predec_hi/lo driven from the latched address; predec_en=1; wl_en=0.
//   - This is the settling cycle for the predecoder outputs.
// - ACTIVE: wl_en=1 for WL_CYCLES cycles; address and predec_en held.
// - RECOVER (1 cycle):
//   - wl_en=0; address held; done=1 and done_id driven this cycle.
//   - Next state is IDLE.
// - Invariants:
//   - Latency from accept edge to done = PRE_CYCLES+WL_CYCLES+2 cycles (default 5).
//   - precharge_n=0 and wl_en=1 are never true in the same cycle.
//   - predec_hi/lo change only on entry to DECODE and never while wl_en=1.
//   - Outside DECODE..RECOVER, predec_hi/lo hold their last value.
// - Back-to-back: a request already waiting is accepted in the IDLE cycle after RECOVER. Minimum accept spacing is latency+1.
// - Phase counter: 4 bits, loaded with (cycles-1) on entry to each phase, decrements to 0, no wrap.
// STRUCTURE
// - Shared package sram_ctrl_pkg: state enum {IDLE,PRECHARGE,DECODE,ACTIVE,RECOVER}, ROW_ADDR_W=4, PHASE_CNT_W=4.
// - One sub-module, rr_arbiter_2: two requests in, one-hot grant out, pointer advances on accept.
// - The FSM plus phase counter live in this module.
// TESTING
// - Reset: rst_n=0 for 2 cycles with both ports valid -> all outputs at reset values, no ready, precharge_n=1.
// - Single read: port 0, addr=4'hB, we=0, defaults ->
//   - precharge_n low 1 cycle;
//   - predec_hi=2'b10, predec_lo=2'b11 from DECODE onward;
//   - wl_en high 2 cycles;
//   - done with done_id=0 exactly 5 cycles after accept.
// - Contention: both valid every cycle, addr0=4'h1, addr1=4'h2 -> accepts alternate 0,1,0,1; done_id sequence 0,1,0,1; accept spacing 6 cycles.
// - Parameter sweep: PRE_CYCLES=3, WL_CYCLES=4 -> precharge_n low 3 cycles, wl_en high 4, done 9 cycles after accept.
// - Mid-reset: assert rst_n=0 during the 2nd ACTIVE cycle -> wl_en=0 on the next edge, no done, next request served normally.
// - Invariant checks: precharge_n=0 never coincides with wl_en=1; predec_hi/lo never change while wl_en=1.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM row access controller.
package sram_ctrl_pkg;

    localparam int ROW_ADDR_W  = 4;
    localparam int PHASE_CNT_W = 4;
    localparam int PREDEC_W    = 2;

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        DECODE,
        ACTIVE,
        RECOVER
    } state_e;

    typedef logic [PHASE_CNT_W-1:0] phase_cnt_t;

    // One accepted access as latched on the accept edge.
    typedef struct packed {
        logic [ROW_ADDR_W-1:0] addr;
        logic                  we;
        logic                  id;
    } access_t;

    // Phase counter preload: a phase of N cycles counts N-1 down to 0.
    function automatic phase_cnt_t phase_load(input int unsigned cycles);
        return phase_cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-port round-robin arbiter; the pointer favours the port that did not win last.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            if (req_i == 2'b11) begin
                grant_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                grant_o = req_i;
            end
        end
    end

    // Every grant is an accept, so the pointer moves past the winner.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_o[0]) begin
            ptr_d = 1'b1;
        end else if (grant_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_row_access_ctrl.sv
// Runs one SRAM row access (precharge, predecode, wordline pulse, recover)
// on behalf of one of two round-robin arbitrated requesters.
module sram_row_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int PRE_CYCLES = 1,
    parameter int WL_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_we,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_we,
    output logic              req1_ready,
    output logic [1:0]        predec_hi,
    output logic [1:0]        predec_lo,
    output logic              predec_en,
    output logic              precharge_n,
    output logic              wl_en,
    output logic              we_out,
    output logic              done,
    output logic              done_id
);

    if (ADDR_W != ROW_ADDR_W) begin : g_bad_addr_w
        $error("sram_row_access_ctrl: ADDR_W must be 4");
    end
    if (PRE_CYCLES < 1 || PRE_CYCLES > 15) begin : g_bad_pre
        $error("sram_row_access_ctrl: PRE_CYCLES out of range 1..15");
    end
    if (WL_CYCLES < 1 || WL_CYCLES > 15) begin : g_bad_wl
        $error("sram_row_access_ctrl: WL_CYCLES out of range 1..15");
    end

    state_e                state_q;
    state_e                state_d;
    phase_cnt_t            cnt_q;
    phase_cnt_t            cnt_d;
    access_t               acc_q;
    access_t               acc_d;
    logic [ROW_ADDR_W-1:0] predec_q;
    logic [1:0]            grant;
    logic                  arb_enable;
    logic                  accept;
    logic                  enter_decode;

    // NOTE: ready is gated by rst_n combinationally so nothing is offered while reset is held.
    assign arb_enable = (state_q == IDLE) && rst_n;

    rr_arbiter_2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (arb_enable),
        .req_i    ({req1_valid, req0_valid}),
        .grant_o  (grant)
    );

    assign req0_ready   = grant[0];
    assign req1_ready   = grant[1];
    assign accept       = |grant;
    assign enter_decode = (state_q == PRECHARGE) && (state_d == DECODE);

    always_comb begin
        if (grant[1]) begin
            acc_d = '{addr: req1_addr, we: req1_we, id: 1'b1};
        end else begin
            acc_d = '{addr: req0_addr, we: req0_we, id: 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PRECHARGE;
                    cnt_d   = phase_load(PRE_CYCLES);
                end
            end
            PRECHARGE: begin
                if (cnt_q == '0) begin
                    state_d = DECODE;
                    cnt_d   = phase_load(1);
                end else begin
                    cnt_d = cnt_q - phase_cnt_t'(1);
                end
            end
            DECODE: begin
                state_d = ACTIVE;
                cnt_d   = phase_load(WL_CYCLES);
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = phase_load(1);
                end else begin
                    cnt_d = cnt_q - phase_cnt_t'(1);
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the latched access and predecoder address are reset because they drive outputs with defined reset values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            predec_q <= '0;
        end else begin
            if (accept) begin
                acc_q <= acc_d;
            end
            // Predecoder inputs move only on DECODE entry, never under an open wordline.
            if (enter_decode) begin
                predec_q <= acc_q.addr;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        precharge_n = 1'b1;
        predec_en   = 1'b0;
        wl_en       = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            PRECHARGE: precharge_n = 1'b0;
            DECODE:    predec_en   = 1'b1;
            ACTIVE: begin
                predec_en = 1'b1;
                wl_en     = 1'b1;
            end
            RECOVER: begin
                predec_en = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign predec_hi = predec_q[ROW_ADDR_W-1 -: PREDEC_W];
    assign predec_lo = predec_q[PREDEC_W-1:0];
    assign we_out    = acc_q.we;
    assign done_id   = acc_q.id;

endmodule

// File: tb/tb_sram_row_access_ctrl.sv
// Self-checking bench: default instance plus a PRE=3/WL=4 instance, cycle model and done scoreboard.
module tb_sram_row_access_ctrl;

    typedef struct {
        logic       id;
        logic [3:0] addr;
        logic       we;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n [2];
    logic       v0 [2];
    logic       v1 [2];
    logic       we0 [2];
    logic       we1 [2];
    logic [3:0] a0 [2];
    logic [3:0] a1 [2];
    logic       r0 [2];
    logic       r1 [2];
    logic [1:0] phi [2];
    logic [1:0] plo [2];
    logic       pen [2];
    logic       pcn [2];
    logic       wl [2];
    logic       weo [2];
    logic       dn [2];
    logic       did [2];

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic       rst_at_edge [2];

    bit         busy [2];
    int         acc_c [2];
    logic       ptr [2];
    logic [3:0] m_addr [2];
    logic       m_we [2];
    logic       m_id [2];
    logic [3:0] m_pred [2];
    logic [3:0] prev_pred [2];
    exp_t       sb_q [2][$];
    int         act_acc_cyc [$];
    logic       act_acc_id [$];
    logic       did_log [$];

    always #5 clk = ~clk;

    sram_row_access_ctrl #(.ADDR_W(4), .PRE_CYCLES(1), .WL_CYCLES(2)) u_dut_def (
        .clk(clk), .rst_n(rst_n[0]),
        .req0_valid(v0[0]), .req0_addr(a0[0]), .req0_we(we0[0]), .req0_ready(r0[0]),
        .req1_valid(v1[0]), .req1_addr(a1[0]), .req1_we(we1[0]), .req1_ready(r1[0]),
        .predec_hi(phi[0]), .predec_lo(plo[0]), .predec_en(pen[0]), .precharge_n(pcn[0]),
        .wl_en(wl[0]), .we_out(weo[0]), .done(dn[0]), .done_id(did[0])
    );

    sram_row_access_ctrl #(.ADDR_W(4), .PRE_CYCLES(3), .WL_CYCLES(4)) u_dut_swp (
        .clk(clk), .rst_n(rst_n[1]),
        .req0_valid(v0[1]), .req0_addr(a0[1]), .req0_we(we0[1]), .req0_ready(r0[1]),
        .req1_valid(v1[1]), .req1_addr(a1[1]), .req1_we(we1[1]), .req1_ready(r1[1]),
        .predec_hi(phi[1]), .predec_lo(plo[1]), .predec_en(pen[1]), .precharge_n(pcn[1]),
        .wl_en(wl[1]), .we_out(weo[1]), .done(dn[1]), .done_id(did[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pre_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int wl_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) rst_at_edge[d] <= rst_n[d];
    end

    task automatic monitor_dut(input int d);
        int   pre;
        int   wlc;
        int   lat;
        int   off;
        logic e_pcn;
        logic e_pen;
        logic e_wl;
        logic e_dn;
        logic e_r0;
        logic e_r1;
        logic idle_ok;
        exp_t e;
        pre = pre_of(d);
        wlc = wl_of(d);
        lat = pre + wlc + 2;

        if (!rst_at_edge[d]) begin
            busy[d]   = 1'b0;
            ptr[d]    = 1'b0;
            m_we[d]   = 1'b0;
            m_id[d]   = 1'b0;
            m_pred[d] = 4'h0;
            sb_q[d].delete();
            check($sformatf("d%0d_rst_done_id", d), did[d], 1'b0);
        end else if (busy[d] && (cyc - acc_c[d]) > lat) begin
            busy[d] = 1'b0;
        end

        off   = cyc - acc_c[d];
        e_pcn = 1'b1;
        e_pen = 1'b0;
        e_wl  = 1'b0;
        e_dn  = 1'b0;
        if (busy[d]) begin
            e_pcn = !(off >= 1 && off <= pre);
            e_pen = off > pre;
            e_wl  = (off >= pre + 2) && (off <= pre + wlc + 1);
            e_dn  = off == lat;
            if (off == pre + 1) m_pred[d] = m_addr[d];
        end

        check($sformatf("d%0d_precharge_n", d), pcn[d], e_pcn);
        check($sformatf("d%0d_predec_en", d), pen[d], e_pen);
        check($sformatf("d%0d_wl_en", d), wl[d], e_wl);
        check($sformatf("d%0d_done", d), dn[d], e_dn);
        check($sformatf("d%0d_predec", d), {phi[d], plo[d]}, m_pred[d]);
        check($sformatf("d%0d_we_out", d), weo[d], m_we[d]);
        check($sformatf("d%0d_pre_and_wl", d), !pcn[d] && wl[d], 1'b0);
        if (wl[d]) check($sformatf("d%0d_predec_stable", d), {phi[d], plo[d]}, prev_pred[d]);
        prev_pred[d] = {phi[d], plo[d]};

        if (dn[d]) begin
            if (sb_q[d].size() == 0) begin
                check($sformatf("d%0d_done_unexpected", d), dn[d], 1'b0);
            end else begin
                e = sb_q[d].pop_front();
                check($sformatf("d%0d_sb_done_id", d), did[d], e.id);
                check($sformatf("d%0d_sb_latency", d), cyc, e.due);
                check($sformatf("d%0d_sb_predec", d), {phi[d], plo[d]}, e.addr);
                check($sformatf("d%0d_sb_we", d), weo[d], e.we);
                if (d == 0) did_log.push_back(did[d]);
            end
        end

        idle_ok = rst_n[d] && !busy[d];
        e_r0    = idle_ok && v0[d] && !(v1[d] && ptr[d]);
        e_r1    = idle_ok && v1[d] && !(v0[d] && !ptr[d]);
        check($sformatf("d%0d_ready0", d), r0[d], e_r0);
        check($sformatf("d%0d_ready1", d), r1[d], e_r1);

        if (d == 0 && ((v0[d] && r0[d]) || (v1[d] && r1[d]))) begin
            act_acc_cyc.push_back(cyc);
            act_acc_id.push_back(r1[d]);
        end

        if (e_r0 || e_r1) begin
            m_id[d]   = e_r1;
            m_addr[d] = e_r1 ? a1[d] : a0[d];
            m_we[d]   = e_r1 ? we1[d] : we0[d];
            ptr[d]    = !e_r1;
            busy[d]   = 1'b1;
            acc_c[d]  = cyc;
            e.id   = m_id[d];
            e.addr = m_addr[d];
            e.we   = m_we[d];
            e.due  = cyc + lat;
            sb_q[d].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) monitor_dut(d);
    end

    task automatic send(input int d, input logic port, input logic [3:0] addr, input logic we);
        bit taken;
        taken = 1'b0;
        if (!port) begin
            v0[d] = 1'b1; a0[d] = addr; we0[d] = we;
        end else begin
            v1[d] = 1'b1; a1[d] = addr; we1[d] = we;
        end
        for (int i = 0; i < 60 && !taken; i++) begin
            @(negedge clk);
            taken = port ? r1[d] : r0[d];
        end
        if (!taken) check($sformatf("d%0d_accept_timeout", d), port ? r1[d] : r0[d], 1'b1);
        @(posedge clk);
        #1;
        v0[d] = 1'b0;
        v1[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        for (int i = 0; i < 100 && sb_q[d].size() != 0; i++) @(negedge clk);
        check($sformatf("d%0d_drain_timeout", d), sb_q[d].size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int d);
        rst_n[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[d] = 1'b1;
    endtask

    initial begin
        logic exp_seq [4];
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            v0[d] = 1'b1; v1[d] = 1'b1;
            a0[d] = 4'h3; a1[d] = 4'h7;
            we0[d] = 1'b1; we1[d] = 1'b1;
            prev_pred[d] = 4'h0;
        end

        // Reset held two cycles with both ports valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", r0[0], 1'b0);
        check("rst_ready1", r1[0], 1'b0);
        check("rst_precharge_n", pcn[0], 1'b1);
        #1;
        for (int d = 0; d < 2; d++) begin
            v0[d] = 1'b0; v1[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) rst_n[d] = 1'b1;

        // Single read then a write from the other port.
        send(0, 1'b0, 4'hB, 1'b0);
        wait_idle(0);
        send(0, 1'b1, 4'h6, 1'b1);
        wait_idle(0);

        // Contention from a fresh pointer.
        pulse_reset(0);
        act_acc_cyc.delete();
        act_acc_id.delete();
        did_log.delete();
        v0[0] = 1'b1; a0[0] = 4'h1; we0[0] = 1'b0;
        v1[0] = 1'b1; a1[0] = 4'h2; we1[0] = 1'b1;
        repeat (26) @(posedge clk);
        #1;
        v0[0] = 1'b0;
        v1[0] = 1'b0;
        wait_idle(0);
        check("cont_accepts", act_acc_cyc.size() >= 4, 1'b1);
        check("cont_dones", did_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < act_acc_id.size()) check($sformatf("cont_acc_id%0d", i), act_acc_id[i], exp_seq[i]);
            if (i < did_log.size()) check($sformatf("cont_done_id%0d", i), did_log[i], exp_seq[i]);
            if (i > 0 && i < act_acc_cyc.size())
                check($sformatf("cont_spacing%0d", i), act_acc_cyc[i] - act_acc_cyc[i-1], 6);
        end

        // Reset during the second ACTIVE cycle, then a normal request.
        send(0, 1'b0, 4'h9, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_wl_before", wl[0], 1'b1);
        rst_n[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        check("midrst_wl_after", wl[0], 1'b0);
        repeat (10) @(posedge clk);
        #1;
        send(0, 1'b1, 4'hC, 1'b0);
        wait_idle(0);

        // Parameter sweep instance.
        send(1, 1'b0, 4'h5, 1'b1);
        wait_idle(1);
        send(1, 1'b1, 4'hA, 1'b0);
        wait_idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
